fpm_operand_loader: RTL and testbench

- Writer side of the multiplier's two-operand staging register file.
- Accepts operands as a narrow W-bit valid/ready beat stream and assembles operand A, then operand B, each N bits.
- When both operands are assembled, presents them on write_data/write_data2 and pulses write_en for exactly one clock, so the register file captures both operands in the same cycle.
- Sits between the external operand bus and the multiplier's input register file.

---
 rtl/fpm_pkg.sv | 20 ++
 rtl/fpm_operand_loader_if.sv | 24 ++
 rtl/fpm_beat_assembler.sv | 56 +++++
 rtl/fpm_operand_loader.sv | 95 +++++++++
 tb/tb_fpm_operand_loader.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fpm_pkg.sv
// Shared types and sizing helpers for the multiplier operand loader.
package fpm_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        COMMIT = 2'd2
    } fpm_state_e;

    // Beats needed to cover an n-bit operand with w-bit beats.
    function automatic int fpm_beats(input int n, input int w);
        return (n + w - 1) / w;
    endfunction

    // Counter wide enough to hold 0..beats.
    function automatic int fpm_cnt_w(input int beats);
        return (beats < 1) ? 1 : $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/fpm_operand_loader_if.sv
// Beat stream in, paired-operand commit out.
interface fpm_operand_loader_if #(
    parameter int N = 25,
    parameter int W = 8
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         abort;
    logic         write_en;
    logic [N-1:0] write_data;
    logic [N-1:0] write_data2;
    logic         busy;

    modport master (
        output in_data, in_valid, abort,
        input  in_ready, write_en, write_data, write_data2, busy
    );

    modport slave (
        input  in_data, in_valid, abort,
        output in_ready, write_en, write_data, write_data2, busy
    );
endinterface

// File: rtl/fpm_beat_assembler.sv
// Packs W-bit beats little-endian into one N-bit operand.
module fpm_beat_assembler
    import fpm_pkg::*;
#(
    parameter int N = 25,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] in_data,
    output logic [N-1:0] value,      // includes the beat accepted this cycle
    output logic         last_beat,
    output logic         cnt_nz
);
    localparam int BEATS = fpm_beats(N, W);
    localparam int CW    = fpm_cnt_w(BEATS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  asm_q, asm_d;
    logic          wr;

    assign wr        = load && !clear;
    assign last_beat = (cnt_q == CW'(BEATS - 1));
    assign cnt_nz    = (cnt_q != '0);
    assign value     = asm_d;

    // Beat counter: wraps to zero after the final beat, cleared on abort.
    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (load)
            cnt_d = last_beat ? '0 : cnt_q + CW'(1);
    end

    // Each operand bit belongs to exactly one beat; bits past N in the
    // last beat simply have no destination.
    for (genvar i = 0; i < N; i++) begin : g_bit
        localparam int BI = i / W;
        localparam int BO = i % W;
        assign asm_d[i] = (wr && cnt_q == CW'(BI)) ? in_data[BO] : asm_q[i];
    end

    // Counter and assembly register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
        end
    end
endmodule

// File: rtl/fpm_operand_loader.sv
// Assembles operand A then B from a beat stream and commits both to the
// register file with a single write_en pulse.
module fpm_operand_loader
    import fpm_pkg::*;
#(
    parameter int N = 25,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fpm_operand_loader_if.slave  bus
);
    fpm_state_e   state_q, state_d;
    logic [N-1:0] wd_q, wd_d, wd2_q, wd2_d;
    logic [N-1:0] val_a, val_b;
    logic         fire, load_a, load_b, clear;
    logic         last_a, last_b, nz_a, nz_b;
    logic         in_load;

    assign in_load = (state_q == LOAD_A) || (state_q == LOAD_B);

    // Ready never depends on in_valid; held low while reset is asserted.
    assign bus.in_ready = !rst && in_load && !bus.abort;
    assign fire         = bus.in_valid && bus.in_ready;
    assign load_a       = fire && (state_q == LOAD_A);
    assign load_b       = fire && (state_q == LOAD_B);
    assign clear        = bus.abort && in_load;

    assign bus.write_en    = (state_q == COMMIT);
    assign bus.write_data  = wd_q;
    assign bus.write_data2 = wd2_q;
    // nz_b can only be set in LOAD_B, where busy is already high.
    assign bus.busy        = (state_q != LOAD_A) || nz_a || nz_b;

    fpm_beat_assembler #(.N(N), .W(W)) u_asm_a (
        .clk       (clk),
        .rst       (rst),
        .load      (load_a),
        .clear     (clear),
        .in_data   (bus.in_data),
        .value     (val_a),
        .last_beat (last_a),
        .cnt_nz    (nz_a)
    );

    fpm_beat_assembler #(.N(N), .W(W)) u_asm_b (
        .clk       (clk),
        .rst       (rst),
        .load      (load_b),
        .clear     (clear),
        .in_data   (bus.in_data),
        .value     (val_b),
        .last_beat (last_b),
        .cnt_nz    (nz_b)
    );

    // Next state; output registers load only on the edge entering COMMIT.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        wd2_d   = wd2_q;
        unique case (state_q)
            LOAD_A: begin
                if (bus.abort)
                    state_d = LOAD_A;
                else if (load_a && last_a)
                    state_d = LOAD_B;
            end
            LOAD_B: begin
                if (bus.abort) begin
                    state_d = LOAD_A;
                end else if (load_b && last_b) begin
                    state_d = COMMIT;
                    wd_d    = val_a;
                    wd2_d   = val_b;  // carries the final B beat
                end
            end
            COMMIT:  state_d = LOAD_A;  // abort is ignored here
            default: state_d = LOAD_A;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_A;
            wd_q    <= '0;
            wd2_q   <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            wd2_q   <= wd2_d;
        end
    end
endmodule

// File: tb/tb_fpm_operand_loader.sv
// Randomized bench for fpm_operand_loader: default W=8 plus W=25 and W=1.
module tb_fpm_operand_loader;
    typedef struct packed {
        logic [24:0] a;
        logic [24:0] b;
    } pair_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    pair_t q0[$], q1[$], q2[$];
    pair_t hold0 = '0;
    logic  we0_prev = 1'b0;
    int    st1 = 0, st2 = 0;

    fpm_operand_loader_if #(.N(25), .W(8))  b0 ();
    fpm_operand_loader_if #(.N(25), .W(25)) b1 ();
    fpm_operand_loader_if #(.N(25), .W(1))  b2 ();

    fpm_operand_loader #(.N(25), .W(8))  u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    fpm_operand_loader #(.N(25), .W(25)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    fpm_operand_loader #(.N(25), .W(1))  u2 (.clk(clk), .rst(rst), .bus(b2.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and run the scoreboards.
    task automatic tick();
        pair_t p;
        @(negedge clk);
        if (rst) begin
            q0.delete(); q1.delete(); q2.delete();
            hold0    = '0;
            we0_prev = 1'b0;
        end else begin
            if (b0.write_en) begin
                chk("we0_pulse", {31'd0, we0_prev}, 32'd0);
                if (q0.size() == 0) chk("we0_unexp", 32'd1, 32'd0);
                else hold0 = q0.pop_front();
            end
            chk("wd0_a", {7'd0, b0.write_data},  {7'd0, hold0.a});
            chk("wd0_b", {7'd0, b0.write_data2}, {7'd0, hold0.b});
            we0_prev = b0.write_en;
            if (b1.write_en) begin
                if (q1.size() == 0) chk("we1_unexp", 32'd1, 32'd0);
                else begin
                    p = q1.pop_front();
                    chk("wd1_a", {7'd0, b1.write_data},  {7'd0, p.a});
                    chk("wd1_b", {7'd0, b1.write_data2}, {7'd0, p.b});
                    chk("lat1", cyc - st1 + 1, 3);
                end
            end
            if (b2.write_en) begin
                if (q2.size() == 0) chk("we2_unexp", 32'd1, 32'd0);
                else begin
                    p = q2.pop_front();
                    chk("wd2_a", {7'd0, b2.write_data},  {7'd0, p.a});
                    chk("wd2_b", {7'd0, b2.write_data2}, {7'd0, p.b});
                    chk("lat2", cyc - st2 + 1, 51);
                end
            end
        end
    endtask

    // Offer one beat on the default instance until it is taken.
    task automatic beat0(input logic [7:0] d);
        int n = 0;
        b0.in_valid = 1'b1;
        b0.in_data  = d;
        #1;
        while (!b0.in_ready && n < 20) begin
            tick(); #1; n++;
        end
        if (n >= 20) chk("beat0_timeout", 32'd0, 32'd1);
        tick();
        b0.in_valid = 1'b0;
        b0.in_data  = 8'($urandom);
    endtask

    // gaps: 0 none, 1 idle before every odd beat, 2 random idles.
    // abort_at >= 0 aborts after that many accepted beats.
    task automatic send_pair0(input logic [24:0] a, input logic [24:0] b,
                              input logic [6:0] pa, input logic [6:0] pb,
                              input int abort_at, input int gaps);
        logic [31:0] ea, eb;
        logic [7:0]  d;
        bit          done = 0;
        ea = {pa, a};
        eb = {pb, b};
        if (abort_at < 0) q0.push_back('{a: a, b: b});
        for (int k = 0; k < 8 && !done; k++) begin
            if (k == abort_at) begin
                b0.in_valid = 1'($urandom);
                b0.abort    = 1'b1;
                #1;
                chk("abort_rdy", {31'd0, b0.in_ready}, 32'd0);
                tick();
                b0.abort    = 1'b0;
                b0.in_valid = 1'b0;
                done = 1;
            end else begin
                if ((gaps == 1 && k[0]) || (gaps == 2 && $urandom_range(0, 2) == 0)) begin
                    b0.in_valid = 1'b0;
                    b0.in_data  = 8'($urandom);
                    tick();
                end
                d = (k < 4) ? ea[8*k +: 8] : eb[8*(k-4) +: 8];
                beat0(d);
            end
        end
    endtask

    initial begin
        logic [24:0] ra, rb;
        int          ab;
        b0.in_valid = 0; b0.in_data = '0; b0.abort = 0;
        b1.in_valid = 0; b1.in_data = '0; b1.abort = 0;
        b2.in_valid = 0; b2.in_data = '0; b2.abort = 0;

        // Power-on reset
        repeat (3) tick();
        chk("rst_we",   {31'd0, b0.write_en}, 32'd0);
        chk("rst_wd",   {7'd0, b0.write_data}, 32'd0);
        chk("rst_wd2",  {7'd0, b0.write_data2}, 32'd0);
        chk("rst_busy", {31'd0, b0.busy}, 32'd0);
        chk("rst_rdy",  {31'd0, b0.in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_rdy",  {31'd0, b0.in_ready}, 32'd1);

        // Directed pair, continuous valid; last A beat carries junk above bit 24
        send_pair0(25'h1ABCDEF, 25'h0123456, 7'h7F, 7'h00, -1, 0);
        chk("p1_we",    {31'd0, b0.write_en}, 32'd1);
        chk("p1_rdy",   {31'd0, b0.in_ready}, 32'd0);
        chk("p1_busy",  {31'd0, b0.busy}, 32'd1);
        chk("p1_wd",    {7'd0, b0.write_data}, 32'h1ABCDEF);
        chk("p1_wd2",   {7'd0, b0.write_data2}, 32'h0123456);
        tick();
        chk("p1_we_off", {31'd0, b0.write_en}, 32'd0);
        chk("p1_idle",   {31'd0, b0.busy}, 32'd0);

        // Valid toggling 1,0,1
        send_pair0(25'h0000001, 25'h1FFFFFF, 7'h55, 7'h2A, -1, 1);
        chk("p2_wd",  {7'd0, b0.write_data}, 32'h0000001);
        chk("p2_wd2", {7'd0, b0.write_data2}, 32'h1FFFFFF);
        tick();

        // Reset in the middle of a pair
        for (int k = 0; k < 5; k++) beat0(8'($urandom));
        chk("mid_busy", {31'd0, b0.busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_wd",   {7'd0, b0.write_data}, 32'd0);
        chk("mr_wd2",  {7'd0, b0.write_data2}, 32'd0);
        chk("mr_we",   {31'd0, b0.write_en}, 32'd0);
        chk("mr_busy", {31'd0, b0.busy}, 32'd0);
        chk("mr_rdy",  {31'd0, b0.in_ready}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("mr_rel_rdy", {31'd0, b0.in_ready}, 32'd1);

        // Abort after three A beats, then a clean pair
        send_pair0(25'($urandom), 25'($urandom), 7'd0, 7'd0, 3, 0);
        chk("ab_busy", {31'd0, b0.busy}, 32'd0);
        send_pair0(25'h0000010, 25'h0000020, 7'd0, 7'd0, -1, 0);
        chk("ab_wd",  {7'd0, b0.write_data}, 32'h0000010);
        chk("ab_wd2", {7'd0, b0.write_data2}, 32'h0000020);

        // Abort raised during the commit cycle is ignored
        tick();
        send_pair0(25'($urandom), 25'($urandom), 7'($urandom), 7'($urandom), -1, 0);
        b0.abort = 1'b1;
        b0.in_valid = 1'b1;
        #1;
        chk("abc_we",  {31'd0, b0.write_en}, 32'd1);
        chk("abc_rdy", {31'd0, b0.in_ready}, 32'd0);
        tick();
        b0.abort = 1'b0;
        b0.in_valid = 1'b0;
        #1;
        chk("abc_rdy2", {31'd0, b0.in_ready}, 32'd1);
        chk("abc_we2",  {31'd0, b0.write_en}, 32'd0);
        chk("abc_busy", {31'd0, b0.busy}, 32'd0);

        // Random pairs with idles and occasional aborts (A or B phase)
        for (int i = 0; i < 30; i++) begin
            ra = 25'($urandom);
            rb = 25'($urandom);
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
            send_pair0(ra, rb, 7'($urandom), 7'($urandom), ab, 2);
        end

        // W=25: one beat per operand
        for (int i = 0; i < 6; i++) begin
            ra = 25'($urandom);
            rb = 25'($urandom);
            q1.push_back('{a: ra, b: rb});
            st1 = cyc;
            b1.in_valid = 1'b1;
            b1.in_data  = ra;
            tick();
            b1.in_data  = rb;
            tick();
            b1.in_valid = 1'b0;
            tick();
        end

        // W=1: one bit per beat
        for (int i = 0; i < 3; i++) begin
            ra = 25'($urandom);
            rb = 25'($urandom);
            q2.push_back('{a: ra, b: rb});
            st2 = cyc;
            b2.in_valid = 1'b1;
            for (int k = 0; k < 25; k++) begin b2.in_data = ra[k]; tick(); end
            for (int k = 0; k < 25; k++) begin b2.in_data = rb[k]; tick(); end
            b2.in_valid = 1'b0;
            tick();
        end

        repeat (4) tick();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
